// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: two-requester write sequencer for a bank of transparent latches.
// Each write runs data setup, then a gate pulse, then a hold, with registered one-hot gates.
// Optional feature macro: LATCH_BANK_SHADOW_EN adds a 'shadow' readback mirror of the latch contents.
module latch_bank_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NLAT   = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned SETUP  = 1,
  parameter int unsigned PULSE  = 2,
  parameter int unsigned HOLD   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic [ADDR_W-1:0]       addr0,
  input  logic [WIDTH-1:0]        data0,
  output logic                    ack0,
  input  logic                    req1,
  input  logic [ADDR_W-1:0]       addr1,
  input  logic [WIDTH-1:0]        data1,
  output logic                    ack1,
  output logic [WIDTH-1:0]        latch_d,
  output logic [NLAT-1:0]         latch_c,
  output logic                    busy,
  output logic                    addr_err
`ifdef LATCH_BANK_SHADOW_EN
  ,
  output logic [NLAT*WIDTH-1:0]   shadow
`endif
);

  localparam int unsigned MAX_SP = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int unsigned MAX_D  = (MAX_SP > HOLD) ? MAX_SP : HOLD;
  localparam int unsigned CNT_W  = $clog2(MAX_D) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_GATE  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_rr;       // requester granted most recently
  logic               r_owner;    // requester of the write in flight
  logic [ADDR_W-1:0]  r_addr;     // captured target latch

  logic               w_elig0;
  logic               w_elig1;
  logic               w_grant;
  logic               w_gsel;
  logic               w_addr_ok;
  logic               w_done;
  logic [NLAT-1:0]    w_onehot;

  logic [WIDTH-1:0]   w_latch_d_nxt;
  logic [NLAT-1:0]    w_latch_c_nxt;
  logic               w_busy_nxt;
  logic               w_ack0_nxt;
  logic               w_ack1_nxt;
  logic               w_err_nxt;

  // A requester whose ack is showing is not re-granted in that same cycle.
  assign w_elig0   = req0 & ~ack0;
  assign w_elig1   = req1 & ~ack1;
  assign w_addr_ok = ({1'b0, r_addr} < (ADDR_W+1)'(NLAT));
  assign w_onehot  = NLAT'(1) << r_addr;

  // State register and phase down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic with round-robin arbitration in IDLE; counter reloads on each state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_gsel      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_grant     = 1'b1;
          w_gsel      = (w_elig0 && w_elig1) ? ~r_rr : w_elig1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CNT_W'(SETUP);
        end
      end
      S_SETUP: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_GATE;
          w_cnt_nxt   = CNT_W'(PULSE);
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_GATE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD);
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Next output values, derived from the state being entered so the registered outputs line up with it.
  always_comb begin
    w_latch_d_nxt = latch_d;
    w_latch_c_nxt = '0;
    w_done        = (r_state == S_HOLD) && (w_state_nxt == S_IDLE);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    if (w_grant) begin
      w_latch_d_nxt = w_gsel ? data1 : data0;
    end
    if ((w_state_nxt == S_GATE) && w_addr_ok) begin
      w_latch_c_nxt = w_onehot;
    end
    w_ack0_nxt = w_done & ~r_owner;
    w_ack1_nxt = w_done & r_owner;
    w_err_nxt  = w_done & ~w_addr_ok;
  end

  // Output registers and grant capture; reset drops the gates immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_d  <= '0;
      latch_c  <= '0;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      addr_err <= 1'b0;
      r_rr     <= 1'b1;
      r_owner  <= 1'b0;
      r_addr   <= '0;
    end else begin
      latch_d  <= w_latch_d_nxt;
      latch_c  <= w_latch_c_nxt;
      busy     <= w_busy_nxt;
      ack0     <= w_ack0_nxt;
      ack1     <= w_ack1_nxt;
      addr_err <= w_err_nxt;
      if (w_grant) begin
        r_rr    <= w_gsel;
        r_owner <= w_gsel;
        r_addr  <= w_gsel ? addr1 : addr0;
      end
    end
  end

`ifdef LATCH_BANK_SHADOW_EN
  // Mirror the written value into its slice on the last gate cycle of an in-range write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if ((r_state == S_GATE) && (w_state_nxt == S_HOLD) && w_addr_ok) begin
      for (int i = 0; i < int'(NLAT); i++) begin
        if (r_addr == ADDR_W'(i)) begin
          shadow[i*WIDTH +: WIDTH] <= latch_d;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: directed scenarios plus random traffic, checked against a
// transaction-timeline model. Two instances run in parallel: NLAT=4 and NLAT=3.
module tb_latch_bank_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2;
  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
  localparam int T = S + P + H;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  data0, data1;

  logic         a_ack0, a_ack1, a_busy, a_err;
  logic [W-1:0] a_d;
  logic [3:0]   a_c;
  logic         b_ack0, b_ack1, b_busy, b_err;
  logic [W-1:0] b_d;
  logic [2:0]   b_c;
`ifdef LATCH_BANK_SHADOW_EN
  logic [4*W-1:0] a_sh;
  logic [3*W-1:0] b_sh;
`endif

  always #5 clk = ~clk;

  latch_bank_ctrl #(.WIDTH(W), .NLAT(4), .ADDR_W(AW), .SETUP(S), .PULSE(P), .HOLD(H)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(a_ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(a_ack1),
    .latch_d(a_d), .latch_c(a_c), .busy(a_busy), .addr_err(a_err)
`ifdef LATCH_BANK_SHADOW_EN
    , .shadow(a_sh)
`endif
  );

  latch_bank_ctrl #(.WIDTH(W), .NLAT(3), .ADDR_W(AW), .SETUP(S), .PULSE(P), .HOLD(H)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(b_ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(b_ack1),
    .latch_d(b_d), .latch_c(b_c), .busy(b_busy), .addr_err(b_err)
`ifdef LATCH_BANK_SHADOW_EN
    , .shadow(b_sh)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: one write at a time, described by its offset k in edges since the grant edge.
  bit           m_active;
  int           m_k;
  int           m_owner;
  int           m_last;
  logic [AW-1:0] m_addr;
  logic [W-1:0] m_d;
  bit           m_ack0, m_ack1;
  logic [W-1:0] m_sh [2][4];
  bit           hold_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_owner  = 0;
    m_last   = 1;
    m_addr   = '0;
    m_d      = '0;
    m_ack0   = 1'b0;
    m_ack1   = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) m_sh[i][j] = '0;
  endtask

  task automatic model_edge();
    bit pa0, pa1, e0, e1;
    int g;
    pa0 = m_ack0;
    pa1 = m_ack1;
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (m_active) begin
      m_k++;
      if (m_k == S + P) begin
        if (int'(m_addr) < 4) m_sh[0][m_addr] = m_d;
        if (int'(m_addr) < 3) m_sh[1][m_addr] = m_d;
      end
      if (m_k == T) begin
        m_active = 1'b0;
        if (m_owner == 0) m_ack0 = 1'b1; else m_ack1 = 1'b1;
      end
    end else begin
      e0 = req0 && !pa0;
      e1 = req1 && !pa1;
      g = -1;
      if (e0 && e1) g = (m_last == 0) ? 1 : 0;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      if (g >= 0) begin
        m_active = 1'b1;
        m_k      = 0;
        m_owner  = g;
        m_last   = g;
        m_addr   = (g == 1) ? addr1 : addr0;
        m_d      = (g == 1) ? data1 : data0;
      end
    end
  endtask

  function automatic logic [31:0] exp_c(input int nl);
    if (m_active && m_k >= S && m_k < S + P && int'(m_addr) < nl)
      return 32'(1) << m_addr;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_err(input int nl);
    return 32'((m_ack0 || m_ack1) && int'(m_addr) >= nl);
  endfunction

  task automatic check_all();
    chk("a_latch_d",  32'(a_d),    32'(m_d));
    chk("a_latch_c",  32'(a_c),    exp_c(4));
    chk("a_busy",     32'(a_busy), 32'(m_active));
    chk("a_ack0",     32'(a_ack0), 32'(m_ack0));
    chk("a_ack1",     32'(a_ack1), 32'(m_ack1));
    chk("a_addr_err", 32'(a_err),  exp_err(4));
    chk("b_latch_d",  32'(b_d),    32'(m_d));
    chk("b_latch_c",  32'(b_c),    exp_c(3));
    chk("b_busy",     32'(b_busy), 32'(m_active));
    chk("b_ack0",     32'(b_ack0), 32'(m_ack0));
    chk("b_ack1",     32'(b_ack1), 32'(m_ack1));
    chk("b_addr_err", 32'(b_err),  exp_err(3));
`ifdef LATCH_BANK_SHADOW_EN
    for (int i = 0; i < 4; i++) chk("a_shadow", 32'(a_sh[i*W +: W]), 32'(m_sh[0][i]));
    for (int i = 0; i < 3; i++) chk("b_shadow", 32'(b_sh[i*W +: W]), 32'(m_sh[1][i]));
`endif
  endtask

  // One clock: advance the model on the edge, check just after it, then retire acked requests.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    check_all();
    if (!hold_mode) begin
      if (m_ack0) req0 = 1'b0;
      if (m_ack1) req1 = 1'b0;
    end else begin
      if (m_ack0) data0 = 8'($urandom);
      if (m_ack1) data1 = 8'($urandom);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_drive();
    if (m_ack0) begin
      if ($urandom_range(0, 1) == 0) req0 = 1'b0;
      else begin addr0 = 2'($urandom_range(0, 3)); data0 = 8'($urandom); end
    end else if (!req0 && $urandom_range(0, 2) == 0) begin
      req0 = 1'b1; addr0 = 2'($urandom_range(0, 3)); data0 = 8'($urandom);
    end
    if (m_ack1) begin
      if ($urandom_range(0, 1) == 0) req1 = 1'b0;
      else begin addr1 = 2'($urandom_range(0, 3)); data1 = 8'($urandom); end
    end else if (!req1 && $urandom_range(0, 2) == 0) begin
      req1 = 1'b1; addr1 = 2'($urandom_range(0, 3)); data1 = 8'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;
    hold_mode = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single write to latch 2.
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    step();
    chk("sw_setup_d", 32'(a_d), 32'h0000_00A5);
    chk("sw_setup_c", 32'(a_c), 32'h0);
    step();
    chk("sw_gate_c",  32'(a_c), 32'h4);
    steps(2);
    chk("sw_hold_c",  32'(a_c), 32'h0);
    step();
    chk("sw_ack0",    32'(a_ack0), 32'h1);
    steps(2);

    // Simultaneous requests from an idle bank.
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h33;
    steps(12);

    // Both held continuously: grants alternate.
    hold_mode = 1'b1;
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h21;
    req1 = 1'b1; addr1 = 2'd2; data1 = 8'h42;
    steps(21);
    hold_mode = 1'b0;
    steps(6);
    req0 = 1'b0; req1 = 1'b0;
    steps(2);

    // Address 3: out of range on the NLAT=3 instance, then a normal write.
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h77;
    steps(6);
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h5A;
    steps(6);
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'hC3;
    steps(6);

    // Asynchronous reset while the gate is high.
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h99;
    steps(2);
    chk("rst_pre_c", 32'(a_c), 32'h2);
    #3;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rst_a_c",    32'(a_c),    32'h0);
    chk("rst_a_busy", 32'(a_busy), 32'h0);
    chk("rst_b_c",    32'(b_c),    32'h0);
    model_reset();
    check_all();
    steps(2);
    @(negedge clk);
    rst_n = 1'b1;
    steps(3);
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'h3C;
    steps(7);

    // Random traffic.
    hold_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      rand_drive();
    end
    hold_mode = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    steps(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
- Write sequencer and arbiter for a bank of NLAT transparent D latches, each with a shared data input D and a private gate C.
- Two requesters share the bank. Each write is scheduled as a fixed-timing sequence:
  - data setup: D driven, C low;
  - gate pulse: C high;
  - hold: C low, D still driven.
- Sits between the control logic and the latch bank; the latches never see overlapping or glitching gates.

Parameters:
- WIDTH, 8, latch data width.
- NLAT, 4, number of latches in the bank.
- ADDR_W, 2, latch address width; NLAT <= 2**ADDR_W.
- SETUP, 1, cycles D is stable before the gate rises (>=1).
- PULSE, 2, cycles the gate is high (>=1).
- HOLD, 1, cycles D is stable after the gate falls (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 write request; held high until ack0.
- addr0  in  ADDR_W  requester 0 target latch.
- data0  in  WIDTH  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1  in  1  requester 1 write request.
- addr1  in  ADDR_W  requester 1 target latch.
- data1  in  WIDTH  requester 1 write data.
- ack1  out  1  one-cycle completion pulse to requester 1.
- latch_d  out  WIDTH  shared D bus to the latch bank.
- latch_c  out  NLAT  one-hot gate, bit i drives C of latch i.
- busy  out  1  high in SETUP, GATE and HOLD.
- addr_err  out  1  one-cycle pulse, together with ack, when the serviced address >= NLAT.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. All outputs are registered, so no combinational glitches reach latch_c.
- Reset values: latch_d=0, latch_c=0, ack0=ack1=0, busy=0, addr_err=0, state=IDLE, rr pointer=1 (requester 0 wins the first tie).
- Reset mid-operation: the in-flight write is abandoned, latch_c drops to 0 immediately, and no ack is issued.
- FSM states: IDLE, SETUP, GATE, HOLD. One down-counter, width clog2(max(SETUP,PULSE,HOLD))+1, is loaded on every state entry.
- IDLE:
  - Eligible requester = reqK high and ackK low (prevents re-grant in the ack cycle).
  - If one is eligible, grant it. If both are, grant the one not granted last, then update the pointer.
  - On grant: capture addr and data, drive latch_d=data, go to SETUP for SETUP cycles.
- SETUP: latch_c=0, latch_d stable. Then go to GATE.
- GATE:
  - latch_c = one-hot(addr) for PULSE cycles.
  - If addr >= NLAT, latch_c stays 0 and the address is flagged.
  - Then go to HOLD.
- HOLD: latch_c=0, latch_d unchanged, for HOLD cycles. Then go to IDLE.
- Completion: ackK is asserted for exactly one cycle, the first IDLE cycle after HOLD; addr_err pulses in the same cycle if flagged. The granted requester's inputs are ignored after capture.
- Latency: request sampled in IDLE at cycle t gives ack at t+SETUP+PULSE+HOLD+1 (t+5 with defaults). Back-to-back writes from different requesters: the new grant may occur in the ack cycle.
- latch_d holds its last value while IDLE.
- latch_c is never high in the same cycle latch_d changes, and at most one bit is ever set.

Optional Feature:
- Macro: LATCH_BANK_SHADOW_EN.
- Defined:
  - Adds output port shadow, NLAT*WIDTH bits, reset 0.
  - Slice i is updated with the captured data on the last GATE cycle of a write to latch i. This mirrors the latch contents for readback and bench checking.
  - Out-of-range writes do not update shadow.
- Undefined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single write: req0=1, addr0=2, data0=8'hA5 -> next cycle latch_d=A5 with latch_c=0; then latch_c=4'b0100 for 2 cycles; then latch_c=0 with latch_d=A5 for 1 cycle; ack0 pulses exactly 1 cycle, 5 cycles after the request was sampled; busy high 4 cycles.
- Simultaneous req0 (addr 0, 8'h11) and req1 (addr 3, 8'h33) from reset -> req0 serviced first (latch_c=0001), req1 granted in ack0's cycle (latch_c=1000); ack0 and ack1 each pulse once, 5 cycles apart.
- Both requests held continuously for 4 writes -> grants alternate 0,1,0,1; no ack to a requester whose request is low.
- addr1=3 with NLAT=3 -> latch_c stays 0 for the whole sequence; ack1 and addr_err pulse together; the next write works normally.
- rst_n dropped during GATE, asynchronously mid-cycle -> latch_c=0 and busy=0 immediately; no ack after release; a fresh request gives full 5-cycle timing.
- LATCH_BANK_SHADOW_EN defined: writes 8'h5A to latch 1, then 8'hC3 to latch 1 -> shadow slice 1 = 5A, then C3; other slices stay 0.
